// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit for the execute stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, both on
// unsigned magnitudes; signs are restored when the result is registered.
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// BUSY  | one radix-2 step per cycle, WIDTH steps in total
// DONE  | hi/lo just written, valid asserted for this one cycle
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic             is_div_q;
  logic             neg_res_q;   // negate product / quotient at the end
  logic             neg_rem_q;   // negate remainder (dividend was negative)
  logic             bzero_q;
  logic [WIDTH-1:0] a_raw_q;     // dividend as presented, for divide-by-zero
  logic [WIDTH-1:0] oper_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q;    // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q;    // multiplier bits / dividend-quotient bits
  logic             valid_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             in_signed;
  logic             in_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_hi_d;
  logic [WIDTH-1:0] step_lo_d;

  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;

  // Operand decode: the most-negative value's magnitude still fits unsigned.
  always_comb begin
    in_signed = ~op[0];
    in_div    = op[1];
    sign_a    = in_signed & a[WIDTH-1];
    sign_b    = in_signed & b[WIDTH-1];
    abs_a     = sign_a ? (~a + 1'b1) : a;
    abs_b     = sign_b ? (~b + 1'b1) : b;
  end

  // One radix-2 step on the accumulator pair.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? oper_q : {WIDTH{1'b0}})};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, oper_q};
    if (is_div_q) begin
      // Bit WIDTH of the trial is set exactly when the subtraction underflowed.
      step_hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo_d = {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      step_hi_d = mul_sum[WIDTH:1];
      step_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final step's output.
  always_comb begin
    prod_mag = {step_hi_d, step_lo_d};
    prod_fix = neg_res_q ? (~prod_mag + 1'b1) : prod_mag;
    if (!is_div_q) begin
      res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
      res_lo_d = prod_fix[WIDTH-1:0];
    end else if (bzero_q) begin
      res_hi_d = a_raw_q;
      res_lo_d = {WIDTH{1'b1}};
    end else begin
      // most-negative / -1 gives magnitude 2^(WIDTH-1); negating wraps back to itself.
      res_hi_d = neg_rem_q ? (~step_hi_d + 1'b1) : step_hi_d;
      res_lo_d = neg_res_q ? (~step_lo_d + 1'b1) : step_lo_d;
    end
  end

  // Stall covers the request cycle and every BUSY cycle.
  always_comb begin
    stall = ((state_q == S_IDLE) & start & ~cancel) | (state_q == S_BUSY);
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_raw_q   <= '0;
      oper_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      valid_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      if (cancel) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_BUSY;
              count_q   <= CW'(WIDTH - 1);
              is_div_q  <= in_div;
              neg_res_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              bzero_q   <= (b == '0);
              a_raw_q   <= a;
              acc_hi_q  <= '0;
              if (in_div) begin
                oper_q   <= abs_b;
                acc_lo_q <= abs_a;
              end else begin
                oper_q   <= abs_a;
                acc_lo_q <= abs_b;
              end
            end
          end
          S_BUSY: begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            if (count_q == '0) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              hi_q    <= res_hi_d;
              lo_q    <= res_lo_d;
            end else begin
              count_q <= count_q - CW'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign valid = valid_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed cases plus randomized operations checked
// against plain 64-bit arithmetic, and a WIDTH=8 instance.
module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, valid;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        stall8, valid8;
  logic [7:0]  hi8, lo8;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .stall(stall), .valid(valid), .hi(hi), .lo(lo)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(1'b0), .stall(stall8), .valid(valid8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: true 64-bit arithmetic; SV / and % truncate toward zero with
  // the remainder taking the dividend's sign.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (y == 32'b0) begin
          eh = x; el = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; eh = r[31:0]; el = q[31:0];
        end else begin
          eh = x % y; el = x / y;
        end
      end
    endcase
  endtask

  // Full operation: start in cycle 0, check stall/valid timing and result in cycle 33.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [31:0] eh, el;
    int bad;
    ref_model(o, x, y, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 chk({tag, ".stall0"}, {63'b0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      #1 if (!stall || valid) bad++;
      @(negedge clk);
    end
    #1;
    chk({tag, ".busy"}, 64'(bad), 64'd0);
    chk({tag, ".valid"}, {63'b0, valid}, 64'd1);
    chk({tag, ".stall_rel"}, {63'b0, stall}, 64'd0);
    chk({tag, ".hi"}, {32'b0, hi}, {32'b0, eh});
    chk({tag, ".lo"}, {32'b0, lo}, {32'b0, el});
  endtask

  // Runs n cycles and reports how many of them had valid high.
  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1 if (valid) seen++;
    end
  endtask

  initial begin
    int seen, bad8;
    logic [31:0] ra, rb;
    logic [31:0] edge_vals [6];
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'h0000_0002;

    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.hi", {32'b0, hi}, 64'd0);
    chk("rst.lo", {32'b0, lo}, 64'd0);
    chk("rst.valid", {63'b0, valid}, 64'd0);
    chk("rst.stall", {63'b0, stall}, 64'd0);
    resetn = 1'b1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max.hi_const", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
    // back-to-back: second start lands in cycle 34, result in cycle 67
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    chk("mult_neg.lo_const", {32'b0, lo}, 64'h0000_0000_FFFF_FFEB);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(2'b11, 32'd5, 32'd0, "divu_zero");
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, "div_zero");

    // start seen in DONE is ignored
    do_op(2'b11, 32'd7, 32'd2, "divu_7_2");
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    #1 chk("done_start.stall", {63'b0, stall}, 64'd0);
    count_valid(40, seen);
    chk("done_start.novalid", 64'(seen), 64'd0);

    // cancel in cycle 10 of a DIV
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1 chk("cancel.stall11", {63'b0, stall}, 64'd0);
    count_valid(40, seen);
    chk("cancel.novalid", 64'(seen), 64'd0);
    chk("cancel.hi", {32'b0, hi}, 64'd1);
    chk("cancel.lo", {32'b0, lo}, 64'd3);

    // cancel together with start drops the start
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    #1 chk("cancel_start.stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1 chk("cancel_start.stall1", {63'b0, stall}, 64'd0);
    count_valid(40, seen);
    chk("cancel_start.novalid", 64'(seen), 64'd0);

    // reset in cycle 10 of a DIV
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("reset_mid.hi", {32'b0, hi}, 64'd0);
    chk("reset_mid.lo", {32'b0, lo}, 64'd0);
    chk("reset_mid.stall", {63'b0, stall}, 64'd0);
    count_valid(40, seen);
    chk("reset_mid.novalid", 64'(seen), 64'd0);

    // randomized operations, mixing in boundary operand values
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      do_op(2'($urandom_range(0, 3)), ra, rb, $sformatf("rnd%0d", i));
    end

    // WIDTH=8 instance: MULT 0x80*0x80, valid in cycle 9
    @(negedge clk);
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    bad8 = 0;
    for (int c = 1; c <= 8; c++) begin
      #1 if (!stall8 || valid8) bad8++;
      @(negedge clk);
    end
    #1;
    chk("w8.busy", 64'(bad8), 64'd0);
    chk("w8.valid", {63'b0, valid8}, 64'd1);
    chk("w8.hi", {56'b0, hi8}, 64'h40);
    chk("w8.lo", {56'b0, lo8}, 64'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
